// File: rtl/esp8266_at_responder.sv
// ESP8266-style AT command responder: assembles command lines, classifies them,
// paces a canned reply out at UART byte rate and runs a '+++'-terminated transparent mode.
module esp8266_at_responder #(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int LINE_MAX  = 48
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic [7:0] trans_data,
    output logic       trans_valid,
    output logic       trans_mode,
    output logic [3:0] cmd_id,
    output logic       cmd_valid,
    output logic       rx_drop,
    output logic [1:0] o_dbg_state
);
    // All strobes (pi_flag, po_flag, trans_valid, cmd_valid, rx_drop) are single-cycle
    // qualifiers with no back-pressure: a byte is consumed in the cycle its flag is high.
    localparam int BAUD_CNT = CLK_FRE / BAUD_RATE * 10;
    localparam int CW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int LW       = $clog2(LINE_MAX + 1);
    localparam int HEAD     = 17;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] PL = 8'h2B;

    localparam logic [8*HEAD-1:0] P_AT    = {{(HEAD-2){8'h00}}, "AT"};
    localparam logic [8*HEAD-1:0] P_SAVE  = "AT+SAVETRANSLINK=";
    localparam logic [8*HEAD-1:0] P_CWMOD = {{(HEAD-10){8'h00}}, "AT+CWMODE="};
    localparam logic [8*HEAD-1:0] P_RST   = {{(HEAD-6){8'h00}}, "AT+RST"};
    localparam logic [8*HEAD-1:0] P_CWJAP = {{(HEAD-9){8'h00}}, "AT+CWJAP="};
    localparam logic [8*HEAD-1:0] P_CIFSR = {{(HEAD-8){8'h00}}, "AT+CIFSR"};
    localparam logic [8*HEAD-1:0] P_CIPST = {{(HEAD-12){8'h00}}, "AT+CIPSTART="};
    localparam logic [8*HEAD-1:0] P_CIPMD = {{(HEAD-11){8'h00}}, "AT+CIPMODE="};
    localparam logic [8*HEAD-1:0] P_CIPSD = {{(HEAD-10){8'h00}}, "AT+CIPSEND"};
    localparam logic [8*HEAD-1:0] P_PLUS  = {{(HEAD-3){8'h00}}, "+++"};

    typedef enum logic [1:0] {RX_LINE = 2'd0, MATCH = 2'd1, REPLY = 2'd2, TRANS = 2'd3} state_t;

    state_t          r_state;
    logic [7:0]      r_buf [HEAD];
    logic [LW-1:0]   r_len;
    logic            r_ovf;
    logic [1:0]      r_plus;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_idx;
    logic [8*HEAD-1:0] w_head;
    logic [3:0]      w_match;
    logic [2:0]      w_rlen;
    logic [7:0]      w_rbyte;

    function automatic logic hit(input logic [8*HEAD-1:0] head, input int len,
                                 input logic [8*HEAD-1:0] pat, input int plen, input logic exact);
        logic ok;
        int   pidx;
        ok = exact ? (len == plen) : (len >= plen);
        for (int k = 0; k < HEAD; k++) begin
            pidx = (k < plen) ? (plen - 1 - k) : 0;
            if (k < plen && head[8*(HEAD-1-k) +: 8] != pat[8*pidx +: 8]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [2:0] reply_len(input logic [3:0] id);
        case (id)
            4'd0:    return 3'd7;
            4'd9:    return 3'd5;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] reply_byte(input logic [3:0] id, input logic [2:0] idx);
        logic [55:0] s;
        int          pos;
        case (id)
            4'd0:    s = "ERROR\015\012";
            4'd9:    s = {{2{8'h00}}, "OK\015\012>"};
            4'd10:   s = {{3{8'h00}}, "++\015\012"};
            default: s = {{3{8'h00}}, "OK\015\012"};
        endcase
        pos = int'(reply_len(id)) - 1 - int'(idx);
        if (pos < 0) pos = 0;
        return s[8*pos +: 8];
    endfunction

    // Only the longest command prefix is ever compared; later bytes just count toward length.
    always_comb begin
        w_head = '0;
        for (int k = 0; k < HEAD; k++) w_head[8*(HEAD-1-k) +: 8] = r_buf[k];
    end

    always_comb begin
        w_match = 4'd0;
        if (!r_ovf) begin
            if      (hit(w_head, int'(r_len), P_PLUS,  3,  1'b1)) w_match = 4'd10;
            else if (hit(w_head, int'(r_len), P_AT,    2,  1'b1)) w_match = 4'd1;
            else if (hit(w_head, int'(r_len), P_RST,   6,  1'b1)) w_match = 4'd4;
            else if (hit(w_head, int'(r_len), P_CIFSR, 8,  1'b1)) w_match = 4'd6;
            else if (hit(w_head, int'(r_len), P_SAVE,  17, 1'b0)) w_match = 4'd2;
            else if (hit(w_head, int'(r_len), P_CIPST, 12, 1'b0)) w_match = 4'd7;
            else if (hit(w_head, int'(r_len), P_CIPMD, 11, 1'b0)) w_match = 4'd8;
            else if (hit(w_head, int'(r_len), P_CIPSD, 10, 1'b1)) w_match = 4'd9;
            else if (hit(w_head, int'(r_len), P_CWMOD, 10, 1'b0)) w_match = 4'd3;
            else if (hit(w_head, int'(r_len), P_CWJAP, 9,  1'b0)) w_match = 4'd5;
        end
    end

    assign w_rlen      = reply_len(cmd_id);
    assign w_rbyte     = reply_byte(cmd_id, r_idx);
    assign o_dbg_state = r_state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= RX_LINE;
            for (int k = 0; k < HEAD; k++) r_buf[k] <= 8'h00;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_plus      <= 2'd0;
            r_baud_cnt  <= '0;
            r_idx       <= 3'd0;
            po_data     <= 8'h00;
            po_flag     <= 1'b0;
            trans_data  <= 8'h00;
            trans_valid <= 1'b0;
            trans_mode  <= 1'b0;
            cmd_id      <= 4'd0;
            cmd_valid   <= 1'b0;
            rx_drop     <= 1'b0;
        end else begin
            po_flag     <= 1'b0;
            trans_valid <= 1'b0;
            cmd_valid   <= 1'b0;
            rx_drop     <= 1'b0;
            case (r_state)
                RX_LINE: begin
                    if (pi_flag) begin
                        if (pi_data == LF) begin
                            if (r_len != '0) r_state <= MATCH;
                        end else if (pi_data != CR) begin
                            if (r_len == LW'(LINE_MAX)) begin
                                rx_drop <= 1'b1;
                                r_ovf   <= 1'b1;
                            end else begin
                                if (int'(r_len) < HEAD) r_buf[r_len] <= pi_data;
                                r_len <= r_len + LW'(1);
                                if (r_len == LW'(2) && r_buf[0] == PL && r_buf[1] == PL && pi_data == PL)
                                    r_state <= MATCH;
                            end
                        end
                    end
                end
                MATCH: begin
                    cmd_id     <= w_match;
                    cmd_valid  <= 1'b1;
                    r_baud_cnt <= '0;
                    r_idx      <= 3'd0;
                    r_state    <= REPLY;
                    if (pi_flag) rx_drop <= 1'b1;
                end
                REPLY: begin
                    if (r_baud_cnt == '0) begin
                        po_flag <= 1'b1;
                        po_data <= w_rbyte;
                    end
                    if (r_baud_cnt == CW'(BAUD_CNT - 1)) begin
                        r_baud_cnt <= '0;
                        if (r_idx == w_rlen - 3'd1) begin
                            r_idx <= 3'd0;
                            r_len <= '0;
                            r_ovf <= 1'b0;
                            r_plus <= 2'd0;
                            r_state <= (cmd_id == 4'd9) ? TRANS : RX_LINE;
                            trans_mode <= (cmd_id == 4'd9);
                            // A byte landing on the exit cycle belongs to the state being entered.
                            if (pi_flag) begin
                                if (cmd_id == 4'd9) begin
                                    trans_data  <= pi_data;
                                    trans_valid <= 1'b1;
                                    r_plus      <= (pi_data == PL) ? 2'd1 : 2'd0;
                                end else if (pi_data != CR && pi_data != LF) begin
                                    r_buf[0] <= pi_data;
                                    r_len    <= LW'(1);
                                end
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            if (pi_flag) rx_drop <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                        if (pi_flag) rx_drop <= 1'b1;
                    end
                end
                TRANS: begin
                    if (pi_flag) begin
                        trans_data  <= pi_data;
                        trans_valid <= 1'b1;
                        if (pi_data != PL) begin
                            r_plus <= 2'd0;
                        end else if (r_plus == 2'd2) begin
                            r_plus     <= 2'd0;
                            cmd_id     <= 4'd10;
                            cmd_valid  <= 1'b1;
                            trans_mode <= 1'b0;
                            r_baud_cnt <= '0;
                            r_idx      <= 3'd0;
                            r_state    <= REPLY;
                        end else begin
                            r_plus <= r_plus + 2'd1;
                        end
                    end
                end
                default: r_state <= RX_LINE;
            endcase
        end
    end
endmodule

// File: tb/tb_esp8266_at_responder.sv
// Directed bench for esp8266_at_responder: command lines, reply bytes and pacing,
// transparent-mode forwarding, overflow drops and mid-reply reset.
module tb_esp8266_at_responder;
    localparam int CLK_FRE   = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int INTERVAL  = 100;        // 1_000_000 / 100_000 * 10
    localparam logic [1:0] S_RX = 2'd0, S_REPLY = 2'd2, S_TRANS = 2'd3;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic [7:0] po_data, trans_data;
    logic       po_flag, trans_valid, trans_mode, cmd_valid, rx_drop;
    logic [3:0] cmd_id;
    logic [1:0] dbg_state;

    esp8266_at_responder #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE), .LINE_MAX(48)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
        .po_data(po_data), .po_flag(po_flag), .trans_data(trans_data), .trans_valid(trans_valid),
        .trans_mode(trans_mode), .cmd_id(cmd_id), .cmd_valid(cmd_valid), .rx_drop(rx_drop),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // observation (monitor is the only writer of these)
    logic [7:0] po_q[$];
    int         po_t[$];
    logic [7:0] trans_q[$];
    logic       lat_q[$];
    logic [3:0] cmd_q[$];
    int         rep_q[$];
    int         drop_cnt = 0;
    int         pulse_err = 0;
    logic       p_po = 0, p_tv = 0, p_cv = 0, p_rd = 0, p_pf = 0;
    logic [7:0] p_pd = 0;
    logic [1:0] p_st = 0;

    always @(negedge sys_clk) begin
        if (po_flag) begin po_q.push_back(po_data); po_t.push_back(cyc); end
        if (trans_valid) begin
            trans_q.push_back(trans_data);
            lat_q.push_back(p_pf && (p_pd == trans_data));
        end
        if (cmd_valid) cmd_q.push_back(cmd_id);
        if (rx_drop) drop_cnt <= drop_cnt + 1;
        if ((po_flag && p_po) || (trans_valid && p_tv) || (cmd_valid && p_cv) || (rx_drop && p_rd))
            pulse_err <= pulse_err + 1;
        if (dbg_state == S_REPLY && p_st != S_REPLY) rep_q.push_back(cyc);
        p_po <= po_flag; p_tv <= trans_valid; p_cv <= cmd_valid; p_rd <= rx_drop;
        p_pf <= pi_flag; p_pd <= pi_data; p_st <= dbg_state;
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        pi_data = b; pi_flag = 1'b1;
        @(posedge sys_clk); #1;
        pi_flag = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_line(input string tag, input string line, input int exp_cmd,
                           input string reply, input logic [1:0] exp_state, input bit inject);
        int  po_b, cmd_b, rep_b, n;
        bit  injected;
        po_b = po_q.size(); cmd_b = cmd_q.size(); rep_b = rep_q.size();
        n = reply.len(); injected = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(reply[i]);
        send_str(line);
        for (int i = 0; i < 3000 && po_q.size() < po_b + n; i++) begin
            if (inject && !injected && po_q.size() > po_b) begin
                send_byte("B");
                injected = 1;
            end else begin
                @(posedge sys_clk);
            end
        end
        repeat (INTERVAL + 5) @(posedge sys_clk);
        @(negedge sys_clk);
        check({tag, "_nbytes"}, po_q.size() - po_b, n);
        check({tag, "_ncmd"}, cmd_q.size() - cmd_b, 1);
        if (cmd_q.size() > cmd_b) check({tag, "_cmd"}, cmd_q[cmd_b], exp_cmd);
        for (int i = 0; i < n; i++) begin
            if (po_q.size() > po_b + i) check($sformatf("%s_b%0d", tag, i), po_q[po_b + i], exp_q[0]);
            void'(exp_q.pop_front());
        end
        for (int i = 1; i < n; i++)
            if (po_t.size() > po_b + i)
                check($sformatf("%s_gap%0d", tag, i), po_t[po_b + i] - po_t[po_b + i - 1], INTERVAL);
        if (rep_q.size() > rep_b && po_t.size() > po_b)
            check({tag, "_lat"}, po_t[po_b] - rep_q[rep_b], 1);
        check({tag, "_state"}, dbg_state, exp_state);
        check({tag, "_tmode"}, trans_mode, exp_state == S_TRANS);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d;
        string s;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_outs", {po_data, po_flag, trans_data, trans_valid, trans_mode, cmd_id, cmd_valid, rx_drop}, 0);
        check("rst_state", dbg_state, S_RX);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // empty line: no command, no reply
        b = po_q.size(); d = cmd_q.size();
        send_str("\015\012");
        repeat (50) @(posedge sys_clk);
        check("empty_lf_reply", po_q.size() - b, 0);
        check("empty_lf_cmd", cmd_q.size() - d, 0);

        do_line("cwmode", "AT+CWMODE=1\015\012", 3, "OK\015\012", S_RX, 0);
        do_line("xyz", "AT+XYZ\015\012", 0, "ERROR\015\012", S_RX, 0);
        do_line("rstx", "AT+RSTX\015\012", 0, "ERROR\015\012", S_RX, 0);
        do_line("plus_line", "+++", 10, "++\015\012", S_RX, 0);
        do_line("cipsend", "AT+CIPSEND\015\012", 9, "OK\015\012>", S_TRANS, 0);

        // transparent forwarding
        b = trans_q.size(); d = cmd_q.size();
        s = "GET\015\012";
        send_str(s);
        repeat (5) @(posedge sys_clk);
        check("get_n", trans_q.size() - b, 5);
        for (int i = 0; i < 5; i++)
            if (trans_q.size() > b + i) begin
                check($sformatf("get_d%0d", i), trans_q[b + i], s[i]);
                check($sformatf("get_lat%0d", i), lat_q[b + i], 1);
            end
        check("get_nocmd", cmd_q.size() - d, 0);

        // escape sequence with a broken run first
        b = trans_q.size();
        s = "+a+++";
        do_line("escape", s, 10, "++\015\012", S_RX, 0);
        check("esc_n", trans_q.size() - b, 5);
        for (int i = 0; i < 5; i++)
            if (trans_q.size() > b + i) check($sformatf("esc_d%0d", i), trans_q[b + i], s[i]);

        // overflow and byte during reply
        d = drop_cnt;
        for (int i = 0; i < 60; i++) send_byte("A");
        repeat (2) @(posedge sys_clk);
        check("ovf_drops", drop_cnt - d, 12);
        do_line("ovf", "\015\012", 0, "ERROR\015\012", S_RX, 1);
        check("reply_drop", drop_cnt - d, 13);
        do_line("post_ovf", "AT\015\012", 1, "OK\015\012", S_RX, 0);

        // reset in the middle of a reply
        b = po_q.size();
        send_str("AT\015\012");
        for (int i = 0; i < 2000 && po_q.size() < b + 2; i++) @(posedge sys_clk);
        check("mid_rst_pre", po_q.size() - b, 2);
        repeat (20) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_outs", {po_data, po_flag, trans_data, trans_valid, trans_mode, cmd_id, cmd_valid, rx_drop}, 0);
        check("mid_rst_state", dbg_state, S_RX);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (3 * INTERVAL) @(posedge sys_clk);
        check("mid_rst_silent", po_q.size() - b, 2);
        do_line("after_rst", "AT\015\012", 1, "OK\015\012", S_RX, 0);

        check("strobe_width", pulse_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/esp8266_at_responder.md
ESP8266_AT_RESPONDER -- requirements
Module: esp8266_at_responder

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial rate used for reply byte pacing.
REQ-003 SHALL have parameter LINE_MAX, default 48, maximum stored command bytes per line (CR/LF excluded).
REQ-004 sys_clk  input  1  system clock, all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pi_data  input  8  received command byte from the UART receiver.
REQ-007 pi_flag  input  1  one-cycle strobe qualifying pi_data.
REQ-008 po_data  output  8  reply byte to the UART transmitter.
REQ-009 po_flag  output  1  one-cycle strobe qualifying po_data.
REQ-010 trans_data  output  8  payload byte forwarded in transparent mode.
REQ-011 trans_valid  output  1  one-cycle strobe qualifying trans_data.
REQ-012 trans_mode  output  1  high while in transparent mode.
REQ-013 cmd_id  output  4  code of last completed line: 0 unknown, 1 "AT", 2 "AT+SAVETRANSLINK=", 3 "AT+CWMODE=", 4 "AT+RST", 5 "AT+CWJAP=", 6 "AT+CIFSR", 7 "AT+CIPSTART=", 8 "AT+CIPMODE=", 9 "AT+CIPSEND", 10 "+++".
REQ-014 cmd_valid  output  1  one-cycle pulse when cmd_id updates.
REQ-015 rx_drop  output  1  one-cycle pulse when a received byte is discarded.

Function
REQ-016 SHALL implement states RX_LINE, MATCH, REPLY, TRANS; reset state RX_LINE.
REQ-017 RX_LINE: each pi_flag byte other than CR (0x0D) and LF (0x0A) SHALL be appended to the line buffer; CR SHALL be ignored.
REQ-018 RX_LINE: LF with non-empty buffer SHALL move to MATCH next cycle; LF with empty buffer SHALL be ignored, no reply, no cmd_valid.
REQ-019 RX_LINE: when the first three buffered bytes are "+++", SHALL move to MATCH immediately without waiting for LF.
REQ-020 Bytes beyond LINE_MAX SHALL be discarded with rx_drop and set an overflow flag; an overflowed line SHALL match as cmd_id 0.
REQ-021 MATCH: single cycle; SHALL compare buffer against the prefixes of REQ-013; codes 1, 4, 6, 9 and 10 require exact length, others prefix only; longest-defined match wins; SHALL set cmd_id and pulse cmd_valid; move to REPLY.
REQ-022 REPLY strings: cmd_id 1-8 "OK\r\n" (4 bytes); 9 "OK\r\n>" (5 bytes); 10 "++\r\n" (4 bytes); 0 "ERROR\r\n" (7 bytes).
REQ-023 REPLY pacing: first po_flag 1 cycle after REPLY entry, consecutive po_flag pulses exactly CLK_FRE/BAUD_RATE*10 cycles apart (4340 at defaults); po_data SHALL be valid and stable whenever po_flag is high.
REQ-024 After the last reply byte's interval expires, SHALL clear the buffer and overflow flag and go to TRANS if cmd_id is 9, else RX_LINE.
REQ-025 pi_flag bytes arriving in MATCH or REPLY SHALL be discarded with rx_drop.
REQ-026 TRANS: trans_mode high; every pi_flag byte SHALL appear on trans_data with trans_valid exactly 1 cycle later, including '+' bytes.
REQ-027 TRANS: a '+' counter SHALL count consecutive '+' bytes, clearing on any other byte; on the third, SHALL set cmd_id 10, pulse cmd_valid, go to REPLY (sends "++\r\n"), then RX_LINE with trans_mode low.
REQ-028 po_flag, trans_valid, cmd_valid, rx_drop SHALL never be high for more than one consecutive cycle.
REQ-029 pi_flag coinciding with a state transition SHALL be processed by the state being entered.

Reset
REQ-030 On sys_rst_n low: state RX_LINE, buffer empty, overflow 0, '+' counter 0, pacing counters 0.
REQ-031 Reset values: po_data 0, po_flag 0, trans_data 0, trans_valid 0, trans_mode 0, cmd_id 0, cmd_valid 0, rx_drop 0.
REQ-032 Reset asserted mid-reply SHALL abort the reply with no further po_flag pulses.

Verification
REQ-033 "AT+CWMODE=1\r\n" -> cmd_id 3, cmd_valid pulse, po bytes 4F 4B 0D 0A spaced 4340 cycles.
REQ-034 "AT+XYZ\r\n" -> cmd_id 0, reply 45 52 52 4F 52 0D 0A.
REQ-035 "AT+CIPSEND\r\n" then "GET\r\n" -> reply 4F 4B 0D 0A 3E, trans_mode 1, trans_data 47 45 54 0D 0A each 1 cycle after input.
REQ-036 In TRANS send "+a+++" -> all five bytes forwarded, cmd_id 10 after third consecutive '+', reply 2B 2B 0D 0A, trans_mode 0.
REQ-037 60 'A' bytes then "\r\n" -> 12 rx_drop pulses, cmd_id 0, ERROR reply; byte sent during reply -> rx_drop, no buffer change.
REQ-038 Reset pulsed after 2nd reply byte of "OK\r\n" -> no further po_flag, all outputs at reset values, next "AT\r\n" answered normally.
